// File: rtl/dqs_dly_scan.sv
// DQS delay calibration sequencer: sweeps delay taps, majority-votes the received
// strobe at each tap, locates rise/fall edges and programs the center tap.
module dqs_dly_scan #(
  parameter int          SETTLE_CYCLES = 16,
  parameter int          SAMPLE_LOG2   = 4,
  parameter logic [7:0]  DLY_FIRST     = 8'h00,
  parameter logic [7:0]  DLY_LAST      = 8'hff
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dly_ready,
  input  logic       dqs_received,
  output logic [7:0] dly_data,
  output logic       ld,
  output logic       set,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [7:0] edge_rise,
  output logic [7:0] edge_fall,
  output logic [7:0] center
);

  // state     | meaning
  // IDLE      | waiting for start, results held
  // WAIT_RDY  | waiting for the delay controller to report ready
  // LOAD      | ld high, dly_data = current tap
  // APPLY     | set high
  // SETTLE    | letting the delay line settle
  // SAMPLE    | accumulating dqs_received into the ones counter
  // EVAL      | classify tap, record edges, pick next tap or finish
  // FIN_LOAD  | ld high, dly_data = center
  // FIN_APPLY | set high for the center tap
  // DONE      | one-cycle completion pulse
  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_APPLY, S_SETTLE,
    S_SAMPLE, S_EVAL, S_FIN_LOAD, S_FIN_APPLY, S_DONE
  } state_t;

  localparam int             NSAMP     = 1 << SAMPLE_LOG2;
  localparam int             OW        = SAMPLE_LOG2 + 1;
  localparam logic [OW-1:0]  HALF      = OW'(NSAMP / 2);
  localparam logic [7:0]     SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]     SAMPLE_LD = 8'(NSAMP - 1);

  state_t          state_q, state_d;
  logic [7:0]      tap_q, tap_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic            seen_low_q, seen_low_d;
  logic            rise_seen_q, rise_seen_d;
  logic            fall_seen_q, fall_seen_d;
  logic [7:0]      edge_rise_q, edge_rise_d;
  logic [7:0]      edge_fall_q, edge_fall_d;
  logic [7:0]      center_q, center_d;
  logic            found_q, found_d;
  logic [7:0]      dly_data_q, dly_data_d;
  logic            tap_high;
  logic            fall_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      seen_low_q  <= 1'b0;
      rise_seen_q <= 1'b0;
      fall_seen_q <= 1'b0;
      edge_rise_q <= '0;
      edge_fall_q <= '0;
      center_q    <= '0;
      found_q     <= 1'b0;
      dly_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      seen_low_q  <= seen_low_d;
      rise_seen_q <= rise_seen_d;
      fall_seen_q <= fall_seen_d;
      edge_rise_q <= edge_rise_d;
      edge_fall_q <= edge_fall_d;
      center_q    <= center_d;
      found_q     <= found_d;
      dly_data_q  <= dly_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    seen_low_d  = seen_low_q;
    rise_seen_d = rise_seen_q;
    fall_seen_d = fall_seen_q;
    edge_rise_d = edge_rise_q;
    edge_fall_d = edge_fall_q;
    center_d    = center_q;
    found_d     = found_q;
    dly_data_d  = dly_data_q;
    tap_high    = 1'b0;
    fall_now    = 1'b0;
    ld          = 1'b0;
    set         = 1'b0;
    busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    done        = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tap_d       = DLY_FIRST;
          seen_low_d  = 1'b0;
          rise_seen_d = 1'b0;
          fall_seen_d = 1'b0;
          edge_rise_d = '0;
          edge_fall_d = '0;
          center_d    = '0;
          found_d     = 1'b0;
          // Ready already: WAIT_RDY takes zero cycles so ld lands right after start.
          if (dly_ready) begin
            dly_data_d = DLY_FIRST;
            state_d    = S_LOAD;
          end else begin
            state_d    = S_WAIT_RDY;
          end
        end
      end
      S_WAIT_RDY: begin
        if (dly_ready) begin
          dly_data_d = tap_q;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        ld      = 1'b1;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        set     = 1'b1;
        cnt_d   = SETTLE_LD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = SAMPLE_LD;
          ones_d  = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        ones_d = ones_q + OW'(dqs_received);
        if (cnt_q == 8'd0) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_EVAL: begin
        tap_high = (ones_q > HALF);
        if (!tap_high) begin
          seen_low_d = 1'b1;
        end
        if (tap_high && seen_low_q && !rise_seen_q) begin
          rise_seen_d = 1'b1;
          edge_rise_d = tap_q;
        end
        if (!tap_high && rise_seen_q && !fall_seen_q) begin
          fall_seen_d = 1'b1;
          edge_fall_d = tap_q;
          fall_now    = 1'b1;
        end
        // A recorded fall always implies a recorded rise, so fall_now means both edges.
        if (fall_now || (tap_q == DLY_LAST)) begin
          found_d    = fall_now;
          center_d   = fall_now ? 8'((9'(edge_rise_d) + 9'(edge_fall_d)) >> 1) : DLY_FIRST;
          dly_data_d = center_d;
          state_d    = S_FIN_LOAD;
        end else begin
          tap_d      = tap_q + 8'd1;
          dly_data_d = tap_q + 8'd1;
          state_d    = S_LOAD;
        end
      end
      S_FIN_LOAD: begin
        ld      = 1'b1;
        state_d = S_FIN_APPLY;
      end
      S_FIN_APPLY: begin
        set     = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dly_data  = dly_data_q;
  assign found     = found_q;
  assign edge_rise = edge_rise_q;
  assign edge_fall = edge_fall_q;
  assign center    = center_q;

endmodule

// File: tb/tb_dqs_dly_scan.sv
// Directed bench for dqs_dly_scan: table of strobe patterns plus hand-written
// sequences for start timing, dly_ready stall, mid-scan reset and repeated start.
module tb_dqs_dly_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dly_ready;
  logic       dqs_received;
  logic [7:0] dly_data;
  logic       ld;
  logic       set;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] edge_rise;
  logic [7:0] edge_fall;
  logic [7:0] center;

  dqs_dly_scan dut (
    .clk(clk), .rst(rst), .start(start), .dly_ready(dly_ready),
    .dqs_received(dqs_received), .dly_data(dly_data), .ld(ld), .set(set),
    .busy(busy), .done(done), .found(found), .edge_rise(edge_rise),
    .edge_fall(edge_fall), .center(center)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int nhigh;
    int found;
    int rise;
    int fall;
    int center;
    int taps;
    int last_tap;
  } vec_t;

  vec_t vecs[7];

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;
  int nhigh = 0;
  int since_set = 1000;

  // Strobe model; idx is the sample index within the SAMPLE window of the current tap.
  function automatic logic model_high(input int m, input int t, input int idx, input int nh);
    case (m)
      0: return (t >= 40) && (t <= 79);
      1: return 1'b1;
      2: return 1'b0;
      3: if (t == 40) return (idx >= 0) && (idx < nh);
         else return (t >= 41) && (t <= 79);
      4: return (t <= 9) || ((t >= 20) && (t <= 29));
      5: return (t >= 200);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) since_set <= set ? 0 : since_set + 1;
  assign dqs_received = model_high(mode, int'(dly_data), since_set - 16, nhigh);

  int         cyc = 0, n_ld = 0, n_set = 0, n_done = 0;
  int         bad_int = 0, bad_set = 0, bad_done = 0, overlap = 0;
  int         last_ld_cyc = 0, last_set_cyc = 0;
  logic [7:0] last_ld_data = '0, prev_ld_data = '0, first_ld_data = '0;
  bit         in_scan = 1'b0, have_ld = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (busy && !in_scan) begin
      in_scan = 1'b1;
      have_ld = 1'b0;
    end
    if (ld) begin
      if (have_ld && (cyc - last_ld_cyc != 35)) bad_int++;
      if (!have_ld) first_ld_data = dly_data;
      have_ld      = 1'b1;
      n_ld++;
      last_ld_cyc  = cyc;
      prev_ld_data = last_ld_data;
      last_ld_data = dly_data;
    end
    if (set) begin
      n_set++;
      if ((cyc - last_ld_cyc != 1) || (dly_data != last_ld_data)) bad_set++;
      last_set_cyc = cyc;
    end
    if (ld && set) overlap++;
    if (done) begin
      n_done++;
      if ((cyc - last_set_cyc != 1) || busy) bad_done++;
    end
    if (!busy) in_scan = 1'b0;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (k < 12000) begin
      @(negedge clk);
      k++;
      if (done) break;
    end
    check({nm, "_timeout"}, int'(k >= 12000), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int s_ld, s_done, s_bi, s_bs, s_bd, s_ov;
    s_ld = n_ld; s_done = n_done; s_bi = bad_int; s_bs = bad_set; s_bd = bad_done; s_ov = overlap;
    mode  = v.mode;
    nhigh = v.nhigh;
    pulse_start();
    wait_done(nm);
    check({nm, "_found"}, int'(found), v.found);
    check({nm, "_rise"}, int'(edge_rise), v.rise);
    check({nm, "_fall"}, int'(edge_fall), v.fall);
    check({nm, "_center"}, int'(center), v.center);
    check({nm, "_taps"}, n_ld - s_ld - 1, v.taps);
    check({nm, "_last_tap"}, int'(prev_ld_data), v.last_tap);
    check({nm, "_final_ld"}, int'(last_ld_data), v.center);
    check({nm, "_done_cnt"}, n_done - s_done, 1);
    check({nm, "_tap_cost"}, bad_int - s_bi, 0);
    check({nm, "_set_stable"}, bad_set - s_bs, 0);
    check({nm, "_done_timing"}, bad_done - s_bd, 0);
    check({nm, "_ld_set_overlap"}, overlap - s_ov, 0);
  endtask

  initial begin
    int s_ld, s_set, s_done, s_bi, k;

    vecs[0] = '{0, 0, 1, 40, 80, 60, 81, 80};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 256, 255};
    vecs[2] = '{2, 0, 0, 0, 0, 0, 256, 255};
    vecs[3] = '{3, 8, 1, 41, 80, 60, 81, 80};
    vecs[4] = '{3, 9, 1, 40, 80, 60, 81, 80};
    vecs[5] = '{4, 0, 1, 20, 30, 25, 31, 30};
    vecs[6] = '{5, 0, 0, 200, 0, 0, 256, 255};

    rst = 1'b1; start = 1'b0; dly_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctl", int'({busy, done, ld, set, found}), 0);
    check("rst_dly_data", int'(dly_data), 0);
    check("rst_edges", int'({edge_rise, edge_fall, center}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // start -> busy and ld next cycle, set the cycle after
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check("t_busy_n1", int'(busy), 1);
    check("t_ld_n1", int'(ld), 1);
    check("t_dly_n1", int'(dly_data), 0);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    check("t_set_n2", int'(set), 1);
    check("t_ld_n2", int'(ld), 0);
    wait_done("t_scan");
    check("t_rise", int'(edge_rise), 40);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // dly_ready held low: no ld until it rises, ld one cycle later
    mode = 0; dly_ready = 1'b0;
    s_ld = n_ld;
    pulse_start();
    repeat (100) @(negedge clk);
    check("rdy_no_ld", n_ld - s_ld, 0);
    check("rdy_busy", int'(busy), 1);
    dly_ready = 1'b1;
    @(posedge clk); #1;
    check("rdy_ld_follows", int'(ld), 1);
    check("rdy_ld_data", int'(dly_data), 0);
    wait_done("rdy_scan");
    check("rdy_center", int'(center), 60);

    // async reset during SAMPLE at tap 20
    mode = 0;
    pulse_start();
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (ld && (dly_data == 8'd20)) break;
    end
    check("rst_reach_tap20", int'(k >= 2000), 0);
    repeat (25) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_dly_data", int'(dly_data), 0);
    check("arst_ctl", int'({done, ld, set, found}), 0);
    check("arst_edges", int'({edge_rise, edge_fall, center}), 0);
    @(negedge clk) rst = 1'b0;
    s_ld = n_ld; s_set = n_set;
    repeat (60) @(negedge clk);
    check("arst_no_ld", n_ld - s_ld, 0);
    check("arst_no_set", n_set - s_set, 0);
    run_vec(vecs[0], "after_rst");
    check("after_rst_first_tap", int'(first_ld_data), 0);

    // repeated start while busy, then start in the done cycle
    mode = 0;
    s_ld = n_ld; s_done = n_done; s_bi = bad_int;
    pulse_start();
    k = 0;
    while (k < 12000) begin
      @(negedge clk);
      k++;
      if (done) begin
        start = 1'b1;
        break;
      end
      start = (k % 7 == 0);
    end
    check("rep_timeout", int'(k >= 12000), 0);
    @(negedge clk) start = 1'b0;
    @(posedge clk); #1;
    check("rep_start_in_done_ignored", int'(busy), 0);
    repeat (20) @(negedge clk);
    check("rep_done_cnt", n_done - s_done, 1);
    check("rep_ld_cnt", n_ld - s_ld, 82);
    check("rep_tap_cost", bad_int - s_bi, 0);
    check("rep_center", int'(center), 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dqs_dly_scan.md
# dqs_dly_scan

Delay-calibration sequencer that drives the 8-bit delay load/set interface of the DQS I/O cell and observes the delayed received strobe. It sweeps delay taps across a programmed range, majority-votes `dqs_received` at each tap, and locates the rising and falling edges of the sampled strobe. It then programs the cell with the center tap. It sits in the `clk_div` domain beside `dqs_single` and replaces manual `dly_data`/`ld`/`set` control during bring-up.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: idle cycles after `set` before sampling; valid range 1..255.
- `SAMPLE_LOG2`, 4: number of samples per tap is 2^SAMPLE_LOG2; valid range 1..8.
- `DLY_FIRST`, 8'h00: first tap of the sweep.
- `DLY_LAST`, 8'hff: last tap of the sweep; must be ≥ `DLY_FIRST`.

Ports:
- `clk` in 1: the only clock, the `clk_div` domain.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a scan.
- `dly_ready` in 1: IDELAYCTRL ready.
- `dqs_received` in 1: delayed strobe sample, already synchronous to `clk`.
- `dly_data` out 8: tap value presented to the delay cell.
- `ld` out 1: one-cycle load strobe.
- `set` out 1: one-cycle apply strobe.
- `busy` out 1: high while a scan is in progress.
- `done` out 1: one-cycle completion pulse.
- `found` out 1: both edges were located in the last scan.
- `edge_rise` out 8: first tap classified high after a tap classified low.
- `edge_fall` out 8: first tap classified low after `edge_rise`.
- `center` out 8: the tap applied at the end of the scan.

## Operation
- Reset: all outputs are 0, the FSM is in IDLE, and all counters are cleared.
- IDLE: on `start`, latch `tap = DLY_FIRST`, clear the edge flags, and go to WAIT_RDY. `start` is ignored outside IDLE.
- WAIT_RDY: hold until `dly_ready` = 1, then go to LOAD. If `dly_ready` drops later, the scan does not pause.
- LOAD: drive `dly_data = tap` and `ld = 1` for one cycle, then go to APPLY.
- APPLY: drive `set = 1` for one cycle, then go to SETTLE.
- SETTLE: count `SETTLE_CYCLES` cycles, then go to SAMPLE.
- SAMPLE: for 2^SAMPLE_LOG2 cycles, add `dqs_received` into a (SAMPLE_LOG2+1)-bit `ones` counter, then go to EVAL.
- EVAL:
  - Classify the tap as high if `ones > 2^(SAMPLE_LOG2-1)`, otherwise low. An exact tie counts as low.
  - Track `seen_low`.
  - The rise edge is the first high tap with `seen_low`=1 and no rise recorded yet.
  - The fall edge is the first low tap after a recorded rise.
  - Once the fall edge is recorded, or `tap == DLY_LAST`, go to FINAL. Otherwise increment `tap` and go to LOAD. The tap never wraps.
- FINAL:
  - If both edges were recorded: `found=1` and `center = (edge_rise + edge_fall) >> 1`, computed with a 9-bit sum and truncated.
  - Otherwise: `found=0` and `center = DLY_FIRST`. `edge_rise` and `edge_fall` hold their recorded values, or 0 if not recorded.
  - Issue LOAD then APPLY using `center`, then go to DONE.
- DONE: pulse `done` for one cycle and return to IDLE.
- `dly_data` holds its last driven value while idle.
- `found`, `edge_*` and `center` hold until the next `start` is accepted, which clears them to 0.
- Reset asserted mid-scan forces IDLE immediately. No `ld` or `set` is emitted until the next `start`.

## Timing
- `start` sampled at edge N: `busy`=1 from N+1.
- When `dly_ready`=1:
  - `ld` is high in cycle N+1 and `set` in N+2.
  - Sampling begins at N+3+SETTLE_CYCLES.
- Per-tap cost: 2 + SETTLE_CYCLES + 2^SAMPLE_LOG2 + 1 (EVAL) cycles. With defaults this is 35 cycles.
- `ld` and `set` are never high in the same cycle. `dly_data` is stable from the `ld` cycle through the `set` cycle.
- `done` occurs one cycle after the final `set`. `busy` falls in the same cycle as `done`.
- `found`, `edge_*` and `center` are valid from the `done` cycle.
- A `start` asserted in the `done` cycle is ignored. It is accepted from the next cycle.

## Test plan
- Strobe model: `dqs_received`=1 for taps 40..79, 0 elsewhere, with default parameters. Required: `edge_rise`=40, `edge_fall`=80, `center`=60, `found`=1, and the final `ld` carries `dly_data`=60. The scan stops after tap 80, with 81 tap iterations.
- `dqs_received` stuck at 1: `found`=0, `edge_rise`=0 (no low seen), `center`=DLY_FIRST, and the sweep ends at tap 255 with `done` pulsing once.
- Tie/noise at a tap: exactly 8 of 16 samples high at tap 40 classifies it low, so `edge_rise`=41. With 9 of 16 high, `edge_rise`=40.
- Hold `dly_ready`=0 for 100 cycles after `start`: no `ld` appears until `dly_ready` rises, and `ld` follows it by one cycle.
- Assert `rst` while in SAMPLE at tap 20: all outputs go to 0 asynchronously. After release, no `ld`/`set` until a new `start`, which rescans from DLY_FIRST.
- Pulse `start` repeatedly while `busy`: there is exactly one `done`, and the per-tap cycle count stays at 35.
